// File: rtl/snoop_pkg.sv
// Shared types for the snooping MESI cache controller: line state, bus command, FSM state.
package snoop_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_BUSRD   = 2'd1,
    CMD_BUSRDX  = 2'd2,
    CMD_BUSUPGR = 2'd3
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WB,
    ST_ARB,
    ST_CMD,
    ST_RESP
  } fsm_e;

endpackage

// File: rtl/snoop_cache_array.sv
// Direct-mapped line storage (tag, MESI state, data) with a CPU-side and a snoop-side port.
module snoop_cache_array
  import snoop_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [$clog2(NUM_LINES)-1:0] cpu_idx_i,
  output logic [TAG_W-1:0]             cpu_tag_o,
  output logic [1:0]                   cpu_st_o,
  output logic [DATA_W-1:0]            cpu_data_o,
  input  logic                         cpu_we_i,
  input  logic [TAG_W-1:0]             cpu_wtag_i,
  input  logic [1:0]                   cpu_wst_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  input  logic [$clog2(NUM_LINES)-1:0] snp_idx_i,
  output logic [TAG_W-1:0]             snp_tag_o,
  output logic [1:0]                   snp_st_o,
  output logic [DATA_W-1:0]            snp_data_o,
  input  logic                         snp_we_i,
  input  logic [1:0]                   snp_wst_i
);

  logic [TAG_W-1:0]  tag_q  [NUM_LINES];
  logic [1:0]        st_q   [NUM_LINES];
  logic [DATA_W-1:0] data_q [NUM_LINES];

  assign cpu_tag_o  = tag_q[cpu_idx_i];
  assign cpu_st_o   = st_q[cpu_idx_i];
  assign cpu_data_o = data_q[cpu_idx_i];
  assign snp_tag_o  = tag_q[snp_idx_i];
  assign snp_st_o   = st_q[snp_idx_i];
  assign snp_data_o = data_q[snp_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        st_q[i]   <= MESI_I;
        data_q[i] <= '0;
      end
    end else begin
      // A local update to the same line overrides the concurrent snoop update.
      if (snp_we_i && !(cpu_we_i && (cpu_idx_i == snp_idx_i)))
        st_q[snp_idx_i] <= snp_wst_i;
      if (cpu_we_i) begin
        tag_q[cpu_idx_i]  <= cpu_wtag_i;
        st_q[cpu_idx_i]   <= cpu_wst_i;
        data_q[cpu_idx_i] <= cpu_wdata_i;
      end
    end
  end

endmodule

// File: rtl/snoop_cache_ctrl.sv
// Snooping MESI cache controller: CPU request FSM, bus command issue and snoop responses.
module snoop_cache_ctrl
  import snoop_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        id,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_rw,
  input  logic [TAG_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_cmd,
  output logic [TAG_W-1:0]  bus_addr,
  input  logic              snp_valid,
  input  logic [1:0]        snp_cmd,
  input  logic [TAG_W-1:0]  snp_addr,
  input  logic [1:0]        snp_src,
  output logic              snp_shared,
  output logic              snp_data_valid,
  output logic [DATA_W-1:0] snp_data,
  input  logic              resp_shared,
  input  logic [DATA_W-1:0] resp_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);

  fsm_e              state_q, state_d;
  bus_cmd_e          pend_cmd_q, pend_cmd_d, eff_cmd;
  logic [TAG_W-1:0]  req_addr_q, req_addr_d, look_addr;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              rsp_hit_q, rsp_hit_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d, fill_data;
  logic [1:0]        fill_st;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic              snp_shared_q, snp_shared_d, snp_dv_q, snp_dv_d, snp_wb_q, snp_wb_d;
  logic [DATA_W-1:0] snp_data_q, snp_data_d, snp_wb_data_q, snp_wb_data_d;
  logic [TAG_W-1:0]  snp_wb_addr_q, snp_wb_addr_d;
  logic              snp_hit;

  logic [IDX_W-1:0]  cpu_idx, snp_idx;
  logic [TAG_W-1:0]  cpu_tag, snp_tag, cpu_wtag;
  logic [1:0]        cpu_st, snp_st, cpu_wst, snp_wst;
  logic [DATA_W-1:0] cpu_rdata, snp_rdata, cpu_wdat;
  logic              cpu_we, snp_we, line_hit;

  snoop_cache_array #(
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) u_array (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .cpu_idx_i   (cpu_idx),
    .cpu_tag_o   (cpu_tag),
    .cpu_st_o    (cpu_st),
    .cpu_data_o  (cpu_rdata),
    .cpu_we_i    (cpu_we),
    .cpu_wtag_i  (cpu_wtag),
    .cpu_wst_i   (cpu_wst),
    .cpu_wdata_i (cpu_wdat),
    .snp_idx_i   (snp_idx),
    .snp_tag_o   (snp_tag),
    .snp_st_o    (snp_st),
    .snp_data_o  (snp_rdata),
    .snp_we_i    (snp_we),
    .snp_wst_i   (snp_wst)
  );

  assign look_addr = (state_q == ST_IDLE) ? cpu_addr : req_addr_q;
  assign cpu_idx   = look_addr[IDX_W-1:0];
  assign line_hit  = (cpu_tag == look_addr) && (cpu_st != MESI_I);
  // An upgrade whose copy was invalidated while waiting must fetch the line again.
  assign eff_cmd   = (pend_cmd_q == CMD_BUSUPGR && !line_hit) ? CMD_BUSRDX : pend_cmd_q;

  always_comb begin
    state_d     = state_q;
    pend_cmd_d  = pend_cmd_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rsp_hit_d   = 1'b0;
    rsp_data_d  = '0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    cpu_we      = 1'b0;
    cpu_wtag    = req_addr_q;
    cpu_wst     = MESI_I;
    cpu_wdat    = '0;
    fill_data   = '0;
    fill_st     = MESI_I;
    cpu_ready   = 1'b0;
    bus_req     = 1'b0;
    bus_cmd     = CMD_NONE;
    bus_addr    = '0;
    rsp_valid   = rsp_hit_q;
    rsp_data    = rsp_data_q;
    wb_valid    = snp_wb_q;
    wb_addr     = snp_wb_addr_q;
    wb_data     = snp_wb_data_q;
    case (state_q)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) begin
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          if (line_hit) begin
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            if (cpu_rw) begin
              rsp_hit_d  = 1'b1;
              rsp_data_d = cpu_rdata;
            end else if (cpu_st == MESI_S) begin
              pend_cmd_d = CMD_BUSUPGR;
              state_d    = ST_ARB;
            end else begin
              cpu_we     = 1'b1;
              cpu_wtag   = cpu_addr;
              cpu_wst    = MESI_M;
              cpu_wdat   = cpu_wdata;
              rsp_hit_d  = 1'b1;
              rsp_data_d = cpu_wdata;
            end
          end else begin
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            pend_cmd_d = cpu_rw ? CMD_BUSRD : CMD_BUSRDX;
            state_d    = (cpu_st == MESI_M) ? ST_WB : ST_ARB;
          end
        end
      end
      ST_WB: begin
        // The shared write-back port goes to a pending snoop first; retry next cycle.
        if (!snp_wb_q) begin
          if (cpu_st == MESI_M) begin
            wb_valid = 1'b1;
            wb_addr  = cpu_tag;
            wb_data  = cpu_rdata;
            cpu_we   = 1'b1;
            cpu_wtag = cpu_tag;
            cpu_wst  = MESI_I;
            cpu_wdat = cpu_rdata;
          end
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        bus_req    = 1'b1;
        pend_cmd_d = eff_cmd;
        if (bus_gnt) state_d = ST_CMD;
      end
      ST_CMD: begin
        bus_cmd    = eff_cmd;
        bus_addr   = req_addr_q;
        pend_cmd_d = eff_cmd;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        if (pend_cmd_q == CMD_BUSRD) begin
          fill_data = resp_shared ? resp_data : mem_data;
          fill_st   = resp_shared ? MESI_S : MESI_E;
        end else begin
          fill_data = req_wdata_q;
          fill_st   = MESI_M;
        end
        cpu_we    = 1'b1;
        cpu_wtag  = req_addr_q;
        cpu_wst   = fill_st;
        cpu_wdat  = fill_data;
        rsp_valid = 1'b1;
        rsp_data  = fill_data;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign snp_idx = snp_addr[IDX_W-1:0];
  assign snp_hit = snp_valid && (snp_src != id) && (snp_cmd != CMD_NONE) &&
                   (snp_tag == snp_addr) && (snp_st != MESI_I);

  always_comb begin
    snp_we        = snp_hit;
    snp_wst       = (snp_cmd == CMD_BUSRD) ? MESI_S : MESI_I;
    snp_shared_d  = snp_hit;
    snp_dv_d      = snp_hit && (snp_cmd != CMD_BUSUPGR);
    snp_data_d    = snp_dv_d ? snp_rdata : '0;
    snp_wb_d      = snp_hit && (snp_st == MESI_M);
    snp_wb_addr_d = snp_wb_d ? snp_tag : '0;
    snp_wb_data_d = snp_wb_d ? snp_rdata : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pend_cmd_q    <= CMD_NONE;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_data_q    <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      snp_shared_q  <= 1'b0;
      snp_dv_q      <= 1'b0;
      snp_data_q    <= '0;
      snp_wb_q      <= 1'b0;
      snp_wb_addr_q <= '0;
      snp_wb_data_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_cmd_q    <= pend_cmd_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_data_q    <= rsp_data_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      snp_shared_q  <= snp_shared_d;
      snp_dv_q      <= snp_dv_d;
      snp_data_q    <= snp_data_d;
      snp_wb_q      <= snp_wb_d;
      snp_wb_addr_q <= snp_wb_addr_d;
      snp_wb_data_q <= snp_wb_data_d;
    end
  end

  assign snp_shared     = snp_shared_q;
  assign snp_data_valid = snp_dv_q;
  assign snp_data       = snp_data_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_snoop_cache_ctrl.sv
// Directed vector bench for snoop_cache_ctrl: per-cycle input/expected-output table plus reset sequences.
module tb_snoop_cache_ctrl;

  typedef struct packed {
    logic       cv; logic rw; logic [2:0] addr; logic [7:0] wd; logic gnt;
    logic       sv; logic [1:0] sc; logic [2:0] sa; logic [1:0] ss;
    logic       rs; logic [7:0] rd; logic [7:0] md;
  } in_t;

  typedef struct packed {
    logic       rdy; logic rv; logic [7:0] rdat; logic breq; logic [1:0] bcmd; logic [2:0] baddr;
    logic       sh; logic sdv; logic [7:0] sdat; logic wv; logic [2:0] waddr; logic [7:0] wdat;
  } out_t;

  typedef struct packed { in_t i; out_t e; } vec_t;

  logic clock = 1'b0, reset_n;
  logic [1:0] id = 2'd0;
  logic cpu_valid, cpu_ready, cpu_rw, rsp_valid, bus_req, bus_gnt, snp_valid;
  logic snp_shared, snp_data_valid, resp_shared, wb_valid;
  logic [2:0] cpu_addr, bus_addr, snp_addr, wb_addr;
  logic [7:0] cpu_wdata, rsp_data, snp_data, resp_data, mem_data, wb_data;
  logic [1:0] bus_cmd, snp_cmd, snp_src;
  logic [15:0] hit_cnt, miss_cnt;
  out_t act;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  snoop_cache_ctrl dut (
    .clock(clock), .reset_n(reset_n), .id(id),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr), .snp_src(snp_src),
    .snp_shared(snp_shared), .snp_data_valid(snp_data_valid), .snp_data(snp_data),
    .resp_shared(resp_shared), .resp_data(resp_data), .mem_data(mem_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  assign act = {cpu_ready, rsp_valid, rsp_data, bus_req, bus_cmd, bus_addr,
                snp_shared, snp_data_valid, snp_data, wb_valid, wb_addr, wb_data};

  function automatic in_t vin(input logic cv, rw, input logic [2:0] a, input logic [7:0] wd,
                              input logic g, sv, input logic [1:0] sc, input logic [2:0] sa,
                              input logic [1:0] ss, input logic rs, input logic [7:0] rd, md);
    vin = {cv, rw, a, wd, g, sv, sc, sa, ss, rs, rd, md};
  endfunction

  function automatic out_t vout(input logic rdy, rv, input logic [7:0] rdat, input logic breq,
                                input logic [1:0] bcmd, input logic [2:0] ba, input logic sh, sdv,
                                input logic [7:0] sdat, input logic wv, input logic [2:0] wa,
                                input logic [7:0] wd);
    vout = {rdy, rv, rdat, breq, bcmd, ba, sh, sdv, sdat, wv, wa, wd};
  endfunction

  task automatic add(input in_t i, input out_t e);
    tbl.push_back({i, e});
  endtask

  task automatic cmp(input string name, input logic [63:0] a, input logic [63:0] e,
                     input logic [63:0] mask);
    n_vec++;
    if ((a & mask) !== (e & mask)) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a & mask, e & mask);
    end
  endtask

  task automatic apply(input in_t v, input out_t e, input string name);
    @(negedge clock);
    {cpu_valid, cpu_rw, cpu_addr, cpu_wdata, bus_gnt, snp_valid, snp_cmd, snp_addr,
     snp_src, resp_shared, resp_data, mem_data} = v;
    #1;
    cmp(name, 64'(act), 64'(e), '1);
  endtask

  // Asynchronous reset mid-cycle: outputs must clear with no clock edge.
  task automatic reset_check(input string name);
    out_t m;
    m = '1;
    m.rdy = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    cmp({name, "_out"}, 64'(act), 64'(0), 64'(m));
    cmp({name, "_cnt"}, {32'd0, hit_cnt, miss_cnt}, 64'(0), '1);
    @(negedge clock);
    {cpu_valid, cpu_rw, cpu_addr, cpu_wdata, bus_gnt, snp_valid, snp_cmd, snp_addr,
     snp_src, resp_shared, resp_data, mem_data} = '0;
    reset_n = 1'b1;
  endtask

  initial begin
    in_t z;
    logic [2:0] probe [4];
    z = '0;
    {cpu_valid, cpu_rw, cpu_addr, cpu_wdata, bus_gnt, snp_valid, snp_cmd, snp_addr,
     snp_src, resp_shared, resp_data, mem_data} = '0;
    reset_n = 1'b0;
    #3 cmp("reset_out", 64'(act & {1'b0, {37{1'b1}}}), 64'(0), '1);
    cmp("reset_cnt", {32'd0, hit_cnt, miss_cnt}, 64'(0), '1);
    @(negedge clock) reset_n = 1'b1;

    // Cold read miss of 0x2, memory supplies A5, line fills E
    add(z,                                              vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(1,1,2,8'h00,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,1,2, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,0, 0,0,0,0, 0,8'h77,8'hA5),     vout(0,1,8'hA5,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Write hit in E: silent upgrade to M
    add(vin(1,0,2,8'h3C,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(1,1,8'h3C,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Snooped BUSRD from src 1 on the M line
    add(vin(0,0,0,8'h00,0, 1,1,2,1, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(1,0,8'h00,0,0,0, 1,1,8'h3C, 1,2,8'h3C));
    // Own-ID snoop is ignored
    add(vin(0,0,0,8'h00,0, 1,2,2,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(1,1,2,8'h00,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(1,1,8'h3C,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Write hit in S, grant withheld 5 cycles, BUSRDX snoop invalidates -> BUSRDX issued
    add(vin(1,0,2,8'h55,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,0, 1,2,2,2, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,1,0,0, 1,1,8'h3C, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,2,2, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,0, 0,0,0,0, 0,8'h00,8'h11),     vout(0,1,8'h55,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Read 0x6 evicts M line 0x2: write-back then BUSRD, shared fill from resp_data
    add(vin(1,1,6,8'h00,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,0,0, 0,0,8'h00, 1,2,8'h55));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,1,6, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,0, 0,0,0,0, 1,8'h9E,8'h44),     vout(0,1,8'h9E,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Write misses fill lines 1 and 3 in M
    add(vin(1,0,1,8'hC1,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,2,1, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,1,8'hC1,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(1,0,3,8'hD3,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,2,3, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,1,8'hD3,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Snoop write-back of line 3 collides with WB of line 1: snoop first, WB one cycle later
    add(vin(1,1,5,8'h00,0, 1,1,3,1, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,0,0, 1,1,8'hD3, 1,3,8'hD3));
    add(z,                                              vout(0,0,8'h00,0,0,0, 0,0,8'h00, 1,1,8'hC1));
    add(vin(0,0,0,8'h00,1, 0,0,0,0, 0,8'h00,8'h00),     vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,0,1,5, 0,0,8'h00, 0,0,8'h00));
    add(vin(0,0,0,8'h00,0, 0,0,0,0, 0,8'h00,8'h5A),     vout(0,1,8'h5A,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(vin(1,0,5,8'h66,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(1,1,8'h66,0,0,0, 0,0,8'h00, 0,0,8'h00));
    // Read 0x2 misses (line holds 0x6 in S) and parks in ARB
    add(vin(1,1,2,8'h00,0, 0,0,0,0, 0,8'h00,8'h00),     vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00));
    add(z,                                              vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00));

    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e, $sformatf("vec%0d", k));

    cmp("hit_cnt", 64'(hit_cnt), 64'd4, '1);
    cmp("miss_cnt", 64'(miss_cnt), 64'd6, '1);
    reset_check("reset_in_arb");

    probe[0] = 3'd6; probe[1] = 3'd2; probe[2] = 3'd5; probe[3] = 3'd3;
    for (int unsigned p = 0; p < 4; p++) begin
      apply(vin(1,1,probe[p],8'h00,0, 0,0,0,0, 0,8'h00,8'h00),
            vout(1,0,8'h00,0,0,0, 0,0,8'h00, 0,0,8'h00), $sformatf("post_rst_acc%0d", p));
      apply(z, vout(0,0,8'h00,1,0,0, 0,0,8'h00, 0,0,8'h00), $sformatf("post_rst_miss%0d", p));
      cmp($sformatf("post_rst_cnt%0d", p), {32'd0, hit_cnt, miss_cnt}, 64'h1, '1);
      reset_check($sformatf("post_rst_clr%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
